// File: rtl/m_unit_pkg.sv
// m_unit_pkg: shared types and constants for the M-extension unit controller.
//   state_e  - controller FSM states
//   func3_e  - RV32M func3 encodings (func3[2] selects the divider)
//   CNT_W    - width of the shared latency/timeout counter
package m_unit_pkg;

  // Wide enough for MUL_LATENCY (<=15) and DIV_TIMEOUT (<=255).
  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_MUL_WAIT = 2'd1,
    S_DIV_WAIT = 2'd2,
    S_DONE     = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    F3_MUL    = 3'b000,
    F3_MULH   = 3'b001,
    F3_MULHSU = 3'b010,
    F3_MULHU  = 3'b011,
    F3_DIV    = 3'b100,
    F3_DIVU   = 3'b101,
    F3_REM    = 3'b110,
    F3_REMU   = 3'b111
  } func3_e;

  function automatic logic is_div_op(logic [2:0] f3);
    return f3[2];
  endfunction

endpackage

// File: rtl/m_unit_cycle_counter.sv
// m_unit_cycle_counter: loadable up/down counter with terminal-value flag.
//   clk, rst     - clock, synchronous active-high reset (count -> 0)
//   load_i       - load load_val_i (wins over en_i)
//   load_val_i   - value to load
//   en_i, up_i   - count enable, direction (1 = up, 0 = down)
//   term_val_i   - terminal value compared against the current count
//   cnt_o        - current count
//   term_o       - cnt_o == term_val_i
module m_unit_cycle_counter
  import m_unit_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  input  logic         up_i,
  input  logic [W-1:0] term_val_i,
  output logic [W-1:0] cnt_o,
  output logic         term_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)    cnt_d = load_val_i;
    else if (en_i) cnt_d = up_i ? cnt_q + W'(1) : cnt_q - W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o  = cnt_q;
  assign term_o = (cnt_q == term_val_i);

endmodule

// File: rtl/m_unit_controller.sv
// m_unit_controller: sequences one RV32M instruction at a time through an
// external fixed-latency multiplier or a handshaked divider.
//   clk, rst                       - clock, synchronous active-high reset
//   id_valid/id_m_type/id_func3/id_rd - decode-stage instruction
//   flush                          - squash the in-flight M instruction
//   mul_start/mul_op               - multiplier launch strobe and op
//   div_start/div_op/div_abort     - divider launch, op, abort
//   div_done                       - divider completion
//   stall                          - hold fetch/decode
//   result_valid/we/rd/is_div      - write-back strobe and attributes
//   busy                           - controller not in IDLE
//   err_timeout                    - sticky divider timeout flag
module m_unit_controller
  import m_unit_pkg::*;
#(
  parameter int unsigned MUL_LATENCY = 3,
  parameter int unsigned DIV_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       id_valid,
  input  logic       id_m_type,
  input  logic [2:0] id_func3,
  input  logic [4:0] id_rd,
  input  logic       flush,
  output logic       mul_start,
  output logic [1:0] mul_op,
  output logic       div_start,
  output logic [1:0] div_op,
  output logic       div_abort,
  input  logic       div_done,
  output logic       stall,
  output logic       result_valid,
  output logic       result_we,
  output logic [4:0] result_rd,
  output logic       result_is_div,
  output logic       busy,
  output logic       err_timeout
);

  localparam logic [CNT_W-1:0] MUL_LAT_C  = CNT_W'(MUL_LATENCY);
  // Timeout counts up from 0 in the first DIV_WAIT cycle, so the last
  // permitted cycle sees DIV_TIMEOUT-1.
  localparam logic [CNT_W-1:0] DIV_TERM_C = CNT_W'(DIV_TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [2:0] f3_q, f3_d;
  logic [4:0] rd_q, rd_d;
  logic       err_q, err_d;

  logic             cnt_load, cnt_en, cnt_up, cnt_term;
  logic [CNT_W-1:0] cnt_load_val, cnt_term_val, cnt;

  logic accept;
  // rst gates accept so stall stays low while reset is held.
  assign accept = id_valid && id_m_type && !flush && !rst;

  // Multiplier counts down to 1; divider timeout counts up.
  assign cnt_term_val = (state_q == S_DIV_WAIT) ? DIV_TERM_C : CNT_W'(1);

  m_unit_cycle_counter #(.W(CNT_W)) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .en_i       (cnt_en),
    .up_i       (cnt_up),
    .term_val_i (cnt_term_val),
    .cnt_o      (cnt),
    .term_o     (cnt_term)
  );

  always_comb begin
    state_d       = state_q;
    f3_d          = f3_q;
    rd_d          = rd_q;
    err_d         = err_q;
    cnt_load      = 1'b0;
    cnt_load_val  = '0;
    cnt_en        = 1'b0;
    cnt_up        = 1'b0;
    mul_start     = 1'b0;
    mul_op        = 2'b00;
    div_start     = 1'b0;
    div_op        = 2'b00;
    div_abort     = 1'b0;
    stall         = 1'b0;
    result_valid  = 1'b0;
    result_we     = 1'b0;
    result_rd     = 5'd0;
    result_is_div = 1'b0;
    busy          = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          stall    = 1'b1;
          f3_d     = id_func3;
          rd_d     = id_rd;
          cnt_load = 1'b1;
          if (is_div_op(id_func3)) begin
            state_d      = S_DIV_WAIT;
            cnt_load_val = '0;
          end else begin
            state_d      = S_MUL_WAIT;
            cnt_load_val = MUL_LAT_C;
          end
        end
      end

      S_MUL_WAIT: begin
        stall     = 1'b1;
        busy      = 1'b1;
        mul_op    = f3_q[1:0];
        // Counter still holds its load value only in the first cycle.
        mul_start = (cnt == MUL_LAT_C);
        if (flush)         state_d = S_IDLE;
        else if (cnt_term) state_d = S_DONE;
        else               cnt_en  = 1'b1;
      end

      S_DIV_WAIT: begin
        stall     = 1'b1;
        busy      = 1'b1;
        div_op    = f3_q[1:0];
        div_start = (cnt == '0);
        // Priority: flush, then div_done, then timeout.
        if (flush) begin
          state_d   = S_IDLE;
          div_abort = !rst;
        end else if (div_done) begin
          state_d   = S_DONE;
        end else if (cnt_term) begin
          state_d   = S_IDLE;
          div_abort = !rst;
          err_d     = 1'b1;
        end else begin
          cnt_en    = 1'b1;
          cnt_up    = 1'b1;
        end
      end

      S_DONE: begin
        busy          = 1'b1;
        result_valid  = !flush && !rst;
        result_we     = result_valid && (rd_q != 5'd0);
        result_rd     = rd_q;
        result_is_div = f3_q[2];
        state_d       = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      f3_q    <= 3'd0;
      rd_q    <= 5'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      f3_q    <= f3_d;
      rd_q    <= rd_d;
      err_q   <= err_d;
    end
  end

  assign err_timeout = err_q;

endmodule
